// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU function codes, flag bit positions and sleep states.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_MAC  = 3'b101;
  localparam logic [2:0] ALU_ANDN = 3'b110;
  localparam logic [2:0] ALU_ORN  = 3'b111;

  localparam int FLAG_NEG   = 3;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 0;

  typedef enum logic [1:0] {
    SLP_ACTIVE = 2'd0,
    SLP_SLEEP  = 2'd1,
    SLP_WAKE   = 2'd2
  } sleep_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_sleep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_sleep_ctrl
// Purpose  : ACTIVE/SLEEP/WAKE low-power controller for the shared ALU.
//            Built only when ALU_ARB_SLEEP_EN is defined; otherwise always ACTIVE.
// Revision : 1.0  initial release
// ============================================================================
module alu_sleep_ctrl
  import alu_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic any_valid,
  input  logic busy,
  output logic active,
  output logic alu_sleep
);

`ifdef ALU_ARB_SLEEP_EN
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYCLES - 1);

  sleep_state_e state_q, state_d;
  logic [7:0]   idle_cnt_q, idle_cnt_d;
  logic [3:0]   wake_cnt_q, wake_cnt_d;
  logic         idle;

  assign idle = ~any_valid & ~busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SLP_ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      SLP_ACTIVE: begin
        // Sleep is only entered on an idle cycle, so nothing is ever in flight.
        if (idle) begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d    = SLP_SLEEP;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 8'd1;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      SLP_SLEEP: begin
        if (any_valid) begin
          state_d    = SLP_WAKE;
          wake_cnt_d = WAKE_LOAD;
        end
      end
      SLP_WAKE: begin
        if (wake_cnt_q == 4'd0) begin
          state_d = SLP_ACTIVE;
        end else begin
          wake_cnt_d = wake_cnt_q - 4'd1;
        end
      end
      default: state_d = SLP_ACTIVE;
    endcase
  end

  assign active    = (state_q == SLP_ACTIVE);
  assign alu_sleep = (state_q == SLP_SLEEP);
`else
  logic       w_unused_in;
  logic [7:0] w_unused_cfg;

  assign w_unused_in  = ^{clk, reset, any_valid, busy};
  assign w_unused_cfg = 8'(IDLE_CYCLES) ^ 8'(WAKE_CYCLES);
  assign active       = 1'b1;
  assign alu_sleep    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one ALU between two requesters with a
//            registered issue/response path; low power via ALU_ARB_SLEEP_EN.
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_f,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_f,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_f,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  input  logic        alu_negative,
  output logic        alu_sleep,
  output logic        busy
);

  logic        active;
  logic        acc0, acc1;
  logic        last_grant_q, last_grant_d;
  logic        issue_v_q, issue_v_d;
  logic        issue_own_q, issue_own_d;
  logic [31:0] issue_a_q, issue_a_d;
  logic [31:0] issue_b_q, issue_b_d;
  logic [2:0]  issue_f_q, issue_f_d;
  logic        rsp0_v_q, rsp0_v_d;
  logic        rsp1_v_q, rsp1_v_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;

  // On a tie the port that did not win last time gets the grant.
  assign req0_ready = active & req0_valid & (~req1_valid | last_grant_q);
  assign req1_ready = active & req1_valid & (~req0_valid | ~last_grant_q);
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;

  always_comb begin
    last_grant_d = last_grant_q;
    issue_v_d    = acc0 | acc1;
    issue_own_d  = issue_own_q;
    issue_a_d    = issue_a_q;
    issue_b_d    = issue_b_q;
    issue_f_d    = issue_f_q;
    if (acc0) begin
      last_grant_d = 1'b0;
      issue_own_d  = 1'b0;
      issue_a_d    = req0_a;
      issue_b_d    = req0_b;
      issue_f_d    = req0_f;
    end else if (acc1) begin
      last_grant_d = 1'b1;
      issue_own_d  = 1'b1;
      issue_a_d    = req1_a;
      issue_b_d    = req1_b;
      issue_f_d    = req1_f;
    end
  end

  always_comb begin
    rsp0_v_d     = issue_v_q & ~issue_own_q;
    rsp1_v_d     = issue_v_q & issue_own_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    if (issue_v_q) begin
      rsp_result_d             = alu_result;
      rsp_flags_d[FLAG_NEG]    = alu_negative;
      rsp_flags_d[FLAG_CARRY]  = alu_carry;
      rsp_flags_d[FLAG_OVF]    = alu_overflow;
      rsp_flags_d[FLAG_ZERO]   = alu_zero;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      issue_v_q    <= 1'b0;
      issue_own_q  <= 1'b0;
      issue_a_q    <= '0;
      issue_b_q    <= '0;
      issue_f_q    <= '0;
      rsp0_v_q     <= 1'b0;
      rsp1_v_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      issue_v_q    <= issue_v_d;
      issue_own_q  <= issue_own_d;
      issue_a_q    <= issue_a_d;
      issue_b_q    <= issue_b_d;
      issue_f_q    <= issue_f_d;
      rsp0_v_q     <= rsp0_v_d;
      rsp1_v_q     <= rsp1_v_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  // Operand registers only load on accept, so the ALU inputs stay quiet when idle.
  assign alu_a      = issue_a_q;
  assign alu_b      = issue_b_q;
  assign alu_f      = issue_f_q;
  assign rsp0_valid = rsp0_v_q;
  assign rsp1_valid = rsp1_v_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = issue_v_q | rsp0_v_q | rsp1_v_q;

  alu_sleep_ctrl #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .WAKE_CYCLES (WAKE_CYCLES)
  ) u_sleep (
    .clk       (clk),
    .reset     (reset),
    .any_valid (req0_valid | req1_valid),
    .busy      (busy),
    .active    (active),
    .alu_sleep (alu_sleep)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter with a behavioural ALU and
//            reference model; sleep behaviour follows ALU_ARB_SLEEP_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int IDLE_CYCLES = 16;
  localparam int WAKE_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_f, req1_f;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_f;
  logic        alu_zero, alu_overflow, alu_carry, alu_negative;
  logic        alu_sleep, busy;

  alu_arbiter #(.IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry(alu_carry), .alu_negative(alu_negative),
    .alu_sleep(alu_sleep), .busy(busy)
  );

  always #5 clk = ~clk;

  // Returns {result, neg, carry, ovf, zero}; SUB carry means borrow.
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
    logic [32:0] wide;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (f)
      ALU_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0];
        c = wide[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALU_SUB: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_MAC:  r = a * b;
      ALU_ANDN: r = a & ~b;
      default:  r = a | ~b;
    endcase
    return {r, r[31], c, v, (r == 32'd0)};
  endfunction

  always_comb {alu_result, alu_negative, alu_carry, alu_overflow, alu_zero} =
      ref_alu(alu_a, alu_b, alu_f);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: pending operation, pending response, power mode.
  int          m_last;
  bit          m_iss_v;
  int          m_own;
  logic [31:0] m_a, m_b, m_res;
  logic [2:0]  m_f;
  logic [3:0]  m_flg;
  bit          m_r0, m_r1;
  int          m_mode;     // 0 active, 1 asleep, 2 waking
  int          m_idle;     // consecutive idle cycles seen while active
  int          m_wake;     // waking cycles still to spend
  int          acc_port;

  task automatic model_init();
    m_last = 1; m_iss_v = 0; m_own = 0;
    m_a = '0; m_b = '0; m_f = '0; m_res = '0; m_flg = '0;
    m_r0 = 0; m_r1 = 0; m_mode = 0; m_idle = 0; m_wake = 0;
  endtask

  task automatic step();
    bit e0, e1, busy_old, idle_now;
    logic [35:0] o;
    @(negedge clk);
    e0 = (m_mode == 0) && req0_valid && (!req1_valid || m_last == 1);
    e1 = (m_mode == 0) && req1_valid && (!req0_valid || m_last == 0);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("rsp0_valid", rsp0_valid, m_r0);
    chk("rsp1_valid", rsp1_valid, m_r1);
    if (m_r0 || m_r1) begin
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_flags", rsp_flags, m_flg);
    end
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_f", alu_f, m_f);
    busy_old = m_iss_v || m_r0 || m_r1;
    chk("busy", busy, busy_old);
    chk("alu_sleep", alu_sleep, m_mode == 1);
    @(posedge clk);
    #1;
    m_r0 = m_iss_v && m_own == 0;
    m_r1 = m_iss_v && m_own == 1;
    if (m_iss_v) begin
      o = ref_alu(m_a, m_b, m_f);
      m_res = o[35:4];
      m_flg = o[3:0];
    end
    acc_port = e0 ? 0 : (e1 ? 1 : -1);
    m_iss_v = e0 || e1;
    if (e0) begin m_a = req0_a; m_b = req0_b; m_f = req0_f; m_own = 0; m_last = 0; end
    if (e1) begin m_a = req1_a; m_b = req1_b; m_f = req1_f; m_own = 1; m_last = 1; end
`ifdef ALU_ARB_SLEEP_EN
    idle_now = !req0_valid && !req1_valid && !busy_old;
    if (m_mode == 0) begin
      m_idle = idle_now ? m_idle + 1 : 0;
      if (m_idle == IDLE_CYCLES) begin m_mode = 1; m_idle = 0; end
    end else if (m_mode == 1) begin
      if (req0_valid || req1_valid) begin m_mode = 2; m_wake = WAKE_CYCLES; end
    end else begin
      m_wake--;
      if (m_wake == 0) m_mode = 0;
    end
`else
    idle_now = 1'b0;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req0_f = '0;
    req1_a = '0; req1_b = '0; req1_f = '0;
    @(posedge clk);
    #1;
    chk("rst_rsp0", rsp0_valid, 0);
    chk("rst_rsp1", rsp1_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_f", alu_f, 0);
    chk("rst_sleep", alu_sleep, 0);
    chk("rst_busy", busy, 0);
    req0_valid = 1;
    #1;
    chk("rst_ready0", req0_ready, 1);
    chk("rst_ready1", req1_ready, 0);
    req0_valid = 0;
    reset = 1'b0;
    model_init();
  endtask

  int g[4];

  initial begin
    acc_port = -1;
    do_reset();

    // Port 0 ADD 5+7
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd7; req0_f = ALU_ADD;
    step();
    req0_valid = 0;
    step();
    chk("add_rsp0", rsp0_valid, 1);
    chk("add_rsp1", rsp1_valid, 0);
    chk("add_result", rsp_result, 32'd12);
    chk("add_flags", rsp_flags, 4'b0000);
    step();

    // Port 1 MAC 6*7
    req1_valid = 1; req1_a = 32'd6; req1_b = 32'd7; req1_f = ALU_MAC;
    step();
    req1_valid = 0;
    step();
    chk("mac_rsp1", rsp1_valid, 1);
    chk("mac_rsp0", rsp0_valid, 0);
    chk("mac_result", rsp_result, 32'd42);
    step();

    // Both ports every cycle: grants must alternate starting with port 0
    req0_valid = 1; req0_a = 32'd3;      req0_b = 32'd5;      req0_f = ALU_SUB;
    req1_valid = 1; req1_a = 32'h0000F0F0; req1_b = 32'h000000FF; req1_f = ALU_ANDN;
    step(); g[0] = acc_port;
    step(); g[1] = acc_port;
    chk("tie_rsp0", rsp0_valid, 1);
    chk("tie_sub_result", rsp_result, 32'hFFFFFFFE);
    chk("tie_sub_flags", rsp_flags, 4'b1100);
    step(); g[2] = acc_port;
    chk("tie_rsp1", rsp1_valid, 1);
    chk("tie_andn_result", rsp_result, 32'h0000F000);
    step(); g[3] = acc_port;
    chk("grant0", g[0], 0);
    chk("grant1", g[1], 1);
    chk("grant2", g[2], 0);
    chk("grant3", g[3], 1);
    req0_valid = 0; req1_valid = 0;
    step(); step();

`ifdef ALU_ARB_SLEEP_EN
    // Sleep after IDLE_CYCLES idle cycles, then wake on demand
    do_reset();
    for (int i = 0; i < IDLE_CYCLES - 1; i++) step();
    chk("pre_sleep", alu_sleep, 0);
    step();
    chk("sleep_entered", alu_sleep, 1);
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd2; req0_f = ALU_ADD;
    step(); step(); step();
    chk("wake_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    step();
    chk("wake_rsp0", rsp0_valid, 1);
    chk("wake_result", rsp_result, 32'd3);

    // Request on the idle-expiry cycle is honoured
    do_reset();
    for (int i = 0; i < IDLE_CYCLES - 1; i++) step();
    req0_valid = 1; req0_a = 32'd9; req0_b = 32'd4; req0_f = ALU_SUB;
    step();
    chk("expiry_accept", acc_port, 0);
    chk("expiry_no_sleep", alu_sleep, 0);
    req0_valid = 0;
    step(); step();
`else
    do_reset();
    for (int i = 0; i < 100; i++) step();
    chk("no_sleep_build", alu_sleep, 0);
`endif

    // Asynchronous reset while an operation is in the issue stage
    req1_valid = 1; req1_a = 32'd11; req1_b = 32'd22; req1_f = ALU_OR;
    step();
    req1_valid = 0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rsp0", rsp0_valid, 0);
    chk("mid_rst_rsp1", rsp1_valid, 0);
    chk("mid_rst_result", rsp_result, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b0;
    model_init();
    step(); step();
    chk("mid_rst_no_rsp", rsp1_valid, 0);

    // Randomised traffic with periodic idle stretches
    for (int i = 0; i < 600; i++) begin
      if ((i % 120) < 25) begin
        req0_valid = 0; req1_valid = 0;
      end else begin
        req0_valid = ($urandom_range(0, 99) < 45);
        req1_valid = ($urandom_range(0, 99) < 45);
      end
      req0_a = $urandom; req0_b = $urandom; req0_f = 3'($urandom_range(0, 7));
      req1_a = $urandom; req1_b = $urandom; req1_f = 3'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
